ysyx_23060111_lsu: RTL and testbench
====================================

Name: ysyx_23060111_lsu

Overview:
Load/store unit sitting directly upstream of ysyx_23060111_mem. It accepts one memory operation at a time from the execute stage over a valid/ready handshake and drives the memory port's read/write address, data and byte masks. For loads it extracts and sign- or zero-extends the lane from the returned word. The result goes to writeback over a second valid/ready handshake. It also detects misaligned and illegal accesses and reports them without touching memory.

Parameters:
LAT, 1, memory access cycles spent in REQ before completion (LAT >= 1); models future bus latency.
XLEN, 32, data/address width.

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  EXU request valid
in_ready  out  1  LSU can accept (high only in IDLE)
in_addr  in  32  effective byte address
in_wdata  in  32  store data, right-aligned
in_funct3  in  3  RV32 load/store funct3
in_is_load  in  1  operation is a load
in_is_store  in  1  operation is a store
m_raddr  out  32  word-aligned read address
m_rmask  out  32  byte-enable in [3:0], upper bits 0
m_ren  out  1  read enable
m_rdata  in  32  read word (combinational from memory)
m_waddr  out  32  word-aligned write address
m_wdata  out  32  store data shifted into byte lane
m_wmask  out  32  byte-enable in [3:0], upper bits 0
m_wen  out  1  write enable, sampled by memory at posedge clk
out_valid  out  1  result valid to WBU
out_ready  in  1  WBU accepts
out_rdata  out  32  extended load data; 0 for stores and errors
out_err  out  1  misaligned or illegal funct3

Behaviour:
- Reset (async, rst_n=0): state=IDLE, counter=0; all outputs 0 except in_ready=1.
- States are IDLE, REQ and RESP.
- IDLE: in_ready=1. Accept on in_valid&in_ready and register addr, wdata, funct3, is_load, is_store.
  - Legal access → REQ with counter=LAT-1.
  - Otherwise → RESP.
- Legality:
  - Load funct3 ∈ {000,001,010,100,101}; store funct3 ∈ {000,001,010}.
  - Halfword with addr[0]=1 is misaligned. Word with addr[1:0]≠0 is misaligned.
  - Both is_load and is_store high, or both low: treated as illegal.
  - Illegal or misaligned → RESP with out_err=1, out_rdata=0, and no m_ren/m_wen pulse.
- Masks: byte 4'b0001, half 4'b0011, word 4'b1111, each shifted left by addr[1:0].
- Addresses: m_raddr = m_waddr = {addr[31:2],2'b00}.
- Store data: m_wdata = wdata << (8*addr[1:0]).
- REQ, load: m_ren=1 and m_rmask valid for every REQ cycle. On the cycle counter==0, the selected lane of m_rdata is captured and extended (LB/LH sign, LBU/LHU zero) → RESP.
- REQ, store: m_wen=1 only on the first REQ cycle, giving exactly one write. Remains in REQ until counter==0, then → RESP with out_rdata=0.
- Counter: decrements each REQ cycle and never wraps below 0.
- Memory outputs: m_ren, m_wen, masks and data are 0 outside REQ.
- RESP: out_valid=1 with out_rdata/out_err stable until out_ready. On out_valid&out_ready → IDLE. No new request is accepted in the same cycle.
- Latency: a legal op gives out_valid LAT+1 cycles after acceptance. An error gives out_valid 1 cycle after acceptance.
- Reset mid-REQ aborts immediately. A store is never issued twice.

Decomposition:
- Shared package/header holds:
  - funct3 constants: LB, LH, LW, LBU, LHU, SB, SH, SW.
  - State encodings: IDLE, REQ, RESP.
- One natural sub-module, ysyx_23060111_lsu_align. It is purely combinational: it takes funct3 and addr[1:0] and produces the byte mask, misalign flag, shifted store data, and extended load data. It is reused by load and store paths.

Test Plan:
1. LB, addr=0x80000003, mem word 0x80AABBCC, LAT=1:
   - m_raddr=0x80000000, m_rmask=0x8.
   - out_rdata=0xFFFFFF80, out_valid 2 cycles after accept.
2. LHU, addr=0x80000002, word 0x8001_1234:
   - m_rmask=0xC, out_rdata=0x00008001.
3. SB, addr=0x80000001, wdata=0x000000EE:
   - m_wdata=0x0000EE00, m_wmask=0x2.
   - m_wen high exactly one cycle; subsequent LW returns 0x..EE.. lane updated.
4. LW, addr=0x80000002:
   - out_err=1, out_rdata=0, m_ren never asserted, out_valid 1 cycle after accept.
5. LAT=3, LW, out_ready held low 4 cycles:
   - m_ren high 3 cycles.
   - out_valid and out_rdata stable throughout; in_ready=0 until handshake completes.
6. rst_n dropped during REQ of an SW:
   - All outputs return to reset values asynchronously.
   - No second m_wen after release; in_ready=1.

Source files
------------

// File: rtl/ysyx_23060111_lsu_pkg.sv
// Shared definitions for the load/store unit: RV32 funct3 codes, FSM states
// and the legality check applied when a request is accepted.
package ysyx_23060111_lsu_pkg;

  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;
  localparam logic [2:0] SB  = 3'b000;
  localparam logic [2:0] SH  = 3'b001;
  localparam logic [2:0] SW  = 3'b010;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } state_t;

  // Exactly one of load/store must be set, and funct3 must be valid for that kind.
  function automatic logic op_legal(input logic [2:0] f3, input logic is_load,
                                    input logic is_store);
    logic ok;
    ok = 1'b0;
    if (is_load && !is_store) begin
      case (f3)
        LB, LH, LW, LBU, LHU: ok = 1'b1;
        default:              ok = 1'b0;
      endcase
    end else if (is_store && !is_load) begin
      case (f3)
        SB, SH, SW: ok = 1'b1;
        default:    ok = 1'b0;
      endcase
    end
    return ok;
  endfunction

endpackage

// File: rtl/ysyx_23060111_lsu_align.sv
// Combinational lane logic: byte mask, misalignment flag, store-data shift and
// load-data extraction with sign/zero extension.
module ysyx_23060111_lsu_align
  import ysyx_23060111_lsu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0]      funct3,
  input  logic [1:0]      addr_lo,
  input  logic [XLEN-1:0] wdata,
  input  logic [XLEN-1:0] rdata,
  output logic [3:0]      mask,
  output logic            misalign,
  output logic [XLEN-1:0] store_data,
  output logic [XLEN-1:0] load_data
);

  logic [XLEN-1:0] lane;
  logic [3:0]      base;

  always_comb begin
    lane       = rdata >> {addr_lo, 3'b000};
    store_data = wdata << {addr_lo, 3'b000};
    base       = 4'b0000;
    misalign   = 1'b0;
    load_data  = '0;
    // funct3[1:0] encodes access size for both loads and stores
    case (funct3[1:0])
      2'b00: base = 4'b0001;
      2'b01: begin
        base     = 4'b0011;
        misalign = addr_lo[0];
      end
      2'b10: begin
        base     = 4'b1111;
        misalign = |addr_lo;
      end
      default: base = 4'b0000;
    endcase
    mask = base << addr_lo;
    case (funct3)
      LB:      load_data = {{(XLEN-8){lane[7]}}, lane[7:0]};
      LH:      load_data = {{(XLEN-16){lane[15]}}, lane[15:0]};
      LW:      load_data = lane;
      LBU:     load_data = {{(XLEN-8){1'b0}}, lane[7:0]};
      LHU:     load_data = {{(XLEN-16){1'b0}}, lane[15:0]};
      default: load_data = '0;
    endcase
  end

endmodule

// File: rtl/ysyx_23060111_lsu.sv
// Load/store unit: one operation at a time from EXU, drives the memory port
// for LAT cycles, returns extended load data or an error flag to WBU.
module ysyx_23060111_lsu
  import ysyx_23060111_lsu_pkg::*;
#(
  parameter int LAT  = 1,
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in_addr,
  input  logic [XLEN-1:0] in_wdata,
  input  logic [2:0]      in_funct3,
  input  logic            in_is_load,
  input  logic            in_is_store,
  output logic [XLEN-1:0] m_raddr,
  output logic [XLEN-1:0] m_rmask,
  output logic            m_ren,
  input  logic [XLEN-1:0] m_rdata,
  output logic [XLEN-1:0] m_waddr,
  output logic [XLEN-1:0] m_wdata,
  output logic [XLEN-1:0] m_wmask,
  output logic            m_wen,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_rdata,
  output logic            out_err
);

  localparam int CW = (LAT > 1) ? $clog2(LAT) : 1;
  localparam logic [CW-1:0] CNT_START = CW'(LAT - 1);

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [XLEN-1:0] addr_q, wdata_q, rdata_q;
  logic [2:0]      funct3_q;
  logic            is_load_q, is_store_q, err_q;

  logic [2:0]      sel_funct3;
  logic [1:0]      sel_addr_lo;
  logic [3:0]      mask;
  logic            misalign;
  logic [XLEN-1:0] store_data, load_data, word_addr;
  logic            rd_act, wr_act;

  // Legality is judged on the live inputs in IDLE, lane logic on the latched op afterwards
  assign sel_funct3  = (state == IDLE) ? in_funct3 : funct3_q;
  assign sel_addr_lo = (state == IDLE) ? in_addr[1:0] : addr_q[1:0];

  ysyx_23060111_lsu_align #(.XLEN(XLEN)) u_align (
    .funct3    (sel_funct3),
    .addr_lo   (sel_addr_lo),
    .wdata     (wdata_q),
    .rdata     (m_rdata),
    .mask      (mask),
    .misalign  (misalign),
    .store_data(store_data),
    .load_data (load_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      funct3_q   <= '0;
      is_load_q  <= 1'b0;
      is_store_q <= 1'b0;
      rdata_q    <= '0;
      err_q      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            addr_q     <= in_addr;
            wdata_q    <= in_wdata;
            funct3_q   <= in_funct3;
            is_load_q  <= in_is_load;
            is_store_q <= in_is_store;
            rdata_q    <= '0;
            if (op_legal(in_funct3, in_is_load, in_is_store) && !misalign) begin
              state <= REQ;
              cnt   <= CNT_START;
              err_q <= 1'b0;
            end else begin
              state <= RESP;
              err_q <= 1'b1;
            end
          end
        end
        REQ: begin
          if (cnt == '0) begin
            state   <= RESP;
            rdata_q <= is_load_q ? load_data : '0;
            err_q   <= 1'b0;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        RESP: begin
          if (out_ready) begin
            state   <= IDLE;
            rdata_q <= '0;
            err_q   <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign word_addr = {addr_q[XLEN-1:2], 2'b00};
  assign rd_act    = (state == REQ) && is_load_q;
  assign wr_act    = (state == REQ) && is_store_q;

  // The write strobe fires only while the counter still holds its start value
  assign m_ren   = rd_act;
  assign m_raddr = rd_act ? word_addr : '0;
  assign m_rmask = rd_act ? {{(XLEN-4){1'b0}}, mask} : '0;
  assign m_wen   = wr_act && (cnt == CNT_START);
  assign m_waddr = wr_act ? word_addr : '0;
  assign m_wdata = wr_act ? store_data : '0;
  assign m_wmask = wr_act ? {{(XLEN-4){1'b0}}, mask} : '0;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == RESP);
  assign out_rdata = rdata_q;
  assign out_err   = err_q;

endmodule

// File: tb/tb_ysyx_23060111_lsu.sv
// Scoreboard bench for the LSU: a LAT=1 and a LAT=3 instance, each with a
// small word memory model, exercised by one task per scenario.
module tb_ysyx_23060111_lsu;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        in_valid[2], in_ready[2], in_is_load[2], in_is_store[2];
  logic [31:0] in_addr[2], in_wdata[2];
  logic [2:0]  in_funct3[2];
  logic [31:0] m_raddr[2], m_rmask[2], m_rdata[2], m_waddr[2], m_wdata[2], m_wmask[2];
  logic        m_ren[2], m_wen[2];
  logic        out_valid[2], out_ready[2], out_err[2];
  logic [31:0] out_rdata[2];

  logic [31:0] mem[2][16];
  logic        pk_en[2];
  logic [3:0]  pk_idx[2];
  logic [31:0] pk_val[2];
  int          ren_cnt[2] = '{0, 0};
  int          wen_cnt[2] = '{0, 0};

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } exp_t;
  exp_t sb[$];

  ysyx_23060111_lsu #(.LAT(1), .XLEN(32)) u_lat1 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_addr(in_addr[0]),
    .in_wdata(in_wdata[0]), .in_funct3(in_funct3[0]), .in_is_load(in_is_load[0]),
    .in_is_store(in_is_store[0]),
    .m_raddr(m_raddr[0]), .m_rmask(m_rmask[0]), .m_ren(m_ren[0]), .m_rdata(m_rdata[0]),
    .m_waddr(m_waddr[0]), .m_wdata(m_wdata[0]), .m_wmask(m_wmask[0]), .m_wen(m_wen[0]),
    .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_rdata(out_rdata[0]),
    .out_err(out_err[0])
  );

  ysyx_23060111_lsu #(.LAT(3), .XLEN(32)) u_lat3 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_addr(in_addr[1]),
    .in_wdata(in_wdata[1]), .in_funct3(in_funct3[1]), .in_is_load(in_is_load[1]),
    .in_is_store(in_is_store[1]),
    .m_raddr(m_raddr[1]), .m_rmask(m_rmask[1]), .m_ren(m_ren[1]), .m_rdata(m_rdata[1]),
    .m_waddr(m_waddr[1]), .m_wdata(m_wdata[1]), .m_wmask(m_wmask[1]), .m_wen(m_wen[1]),
    .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_rdata(out_rdata[1]),
    .out_err(out_err[1])
  );

  // Memory model: combinational read, byte-masked write at posedge, plus a preload port
  assign m_rdata[0] = mem[0][m_raddr[0][5:2]];
  assign m_rdata[1] = mem[1][m_raddr[1][5:2]];

  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (pk_en[d]) mem[d][pk_idx[d]] <= pk_val[d];
      if (m_wen[d]) begin
        for (int b = 0; b < 4; b++)
          if (m_wmask[d][b]) mem[d][m_waddr[d][5:2]][8*b +: 8] <= m_wdata[d][8*b +: 8];
      end
      if (m_ren[d]) ren_cnt[d] <= ren_cnt[d] + 1;
      if (m_wen[d]) wen_cnt[d] <= wen_cnt[d] + 1;
    end
  end

  task automatic poke(input int d, input int idx, input logic [31:0] v);
    pk_en[d]  = 1'b1;
    pk_idx[d] = 4'(idx);
    pk_val[d] = v;
    @(posedge clk); #1;
    pk_en[d] = 1'b0;
  endtask

  task automatic start_op(input int d, input logic [31:0] a, input logic [31:0] wd,
                          input logic [2:0] f3, input logic ld, input logic st,
                          input logic [31:0] exp_rdata, input logic exp_err);
    exp_t e;
    in_addr[d]     = a;
    in_wdata[d]    = wd;
    in_funct3[d]   = f3;
    in_is_load[d]  = ld;
    in_is_store[d] = st;
    in_valid[d]    = 1'b1;
    vectors++;
    if (in_ready[d] !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL in_ready_idle d=%0d got %b want 1", d, in_ready[d]);
    end
    e.rdata = exp_rdata;
    e.err   = exp_err;
    sb.push_back(e);
    @(posedge clk); #1;
    in_valid[d] = 1'b0;
  endtask

  task automatic finish_op(input int d, input int exp_lat, input int hold);
    int          lat = 1;
    exp_t        e;
    logic [31:0] r0;
    while (!out_valid[d] && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    vectors++;
    if (lat != exp_lat) begin
      miscompares++;
      $display("[TB] FAIL latency d=%0d got %0d want %0d", d, lat, exp_lat);
    end
    r0 = out_rdata[d];
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      vectors++;
      if (out_valid[d] !== 1'b1 || out_rdata[d] !== r0 || in_ready[d] !== 1'b0) begin
        miscompares++;
        $display("[TB] FAIL hold_stable d=%0d got valid=%b rdata=%h ready=%b want 1/%h/0",
                 d, out_valid[d], out_rdata[d], in_ready[d], r0);
      end
    end
    out_ready[d] = 1'b1;
    vectors++;
    if (sb.size() == 0) begin
      miscompares++;
      $display("[TB] FAIL scoreboard_empty d=%0d got 0 entries want >=1", d);
    end else begin
      e = sb.pop_front();
      if (out_valid[d] !== 1'b1 || out_rdata[d] !== e.rdata || out_err[d] !== e.err) begin
        miscompares++;
        $display("[TB] FAIL result d=%0d got valid=%b rdata=%h err=%b want 1/%h/%b",
                 d, out_valid[d], out_rdata[d], out_err[d], e.rdata, e.err);
      end
    end
    @(posedge clk); #1;
    out_ready[d] = 1'b0;
    vectors++;
    if (in_ready[d] !== 1'b1 || out_valid[d] !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL return_idle d=%0d got ready=%b valid=%b want 1/0",
               d, in_ready[d], out_valid[d]);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int d = 0; d < 2; d++) begin
      in_valid[d] = 1'b0; in_addr[d] = '0; in_wdata[d] = '0; in_funct3[d] = '0;
      in_is_load[d] = 1'b0; in_is_store[d] = 1'b0; out_ready[d] = 1'b0;
      pk_en[d] = 1'b0; pk_idx[d] = '0; pk_val[d] = '0;
    end
    #12;
    for (int d = 0; d < 2; d++) begin
      vectors++;
      if (in_ready[d] !== 1'b1) begin
        miscompares++;
        $display("[TB] FAIL reset_in_ready d=%0d got %b want 1", d, in_ready[d]);
      end
      vectors++;
      if ({out_valid[d], out_err[d], m_ren[d], m_wen[d]} !== 4'b0 ||
          (out_rdata[d] | m_raddr[d] | m_rmask[d] | m_waddr[d] | m_wdata[d] | m_wmask[d]) !== 32'h0) begin
        miscompares++;
        $display("[TB] FAIL reset_outputs d=%0d got valid=%b err=%b ren=%b wen=%b rdata=%h want all 0",
                 d, out_valid[d], out_err[d], m_ren[d], m_wen[d], out_rdata[d]);
      end
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_load_byte();
    int r0;
    poke(0, 0, 32'h80AABBCC);
    r0 = ren_cnt[0];
    start_op(0, 32'h80000003, 32'h0, 3'b000, 1'b1, 1'b0, 32'hFFFFFF80, 1'b0);
    vectors++;
    if (m_ren[0] !== 1'b1 || m_raddr[0] !== 32'h80000000 || m_rmask[0] !== 32'h8) begin
      miscompares++;
      $display("[TB] FAIL lb_req got ren=%b raddr=%h rmask=%h want 1/80000000/00000008",
               m_ren[0], m_raddr[0], m_rmask[0]);
    end
    finish_op(0, 2, 0);
    vectors++;
    if (ren_cnt[0] - r0 != 1) begin
      miscompares++;
      $display("[TB] FAIL lb_ren_cycles got %0d want 1", ren_cnt[0] - r0);
    end
  endtask

  task automatic test_load_half();
    poke(0, 0, 32'h80011234);
    start_op(0, 32'h80000002, 32'h0, 3'b101, 1'b1, 1'b0, 32'h00008001, 1'b0);
    vectors++;
    if (m_rmask[0] !== 32'hC) begin
      miscompares++;
      $display("[TB] FAIL lhu_rmask got %h want 0000000c", m_rmask[0]);
    end
    finish_op(0, 2, 0);
    start_op(0, 32'h80000002, 32'h0, 3'b001, 1'b1, 1'b0, 32'hFFFF8001, 1'b0);
    finish_op(0, 2, 0);
    start_op(0, 32'h80000000, 32'h0, 3'b100, 1'b1, 1'b0, 32'h00000034, 1'b0);
    finish_op(0, 2, 0);
  endtask

  task automatic test_store();
    int w0;
    w0 = wen_cnt[0];
    start_op(0, 32'h80000001, 32'h000000EE, 3'b000, 1'b0, 1'b1, 32'h0, 1'b0);
    vectors++;
    if (m_wen[0] !== 1'b1 || m_waddr[0] !== 32'h80000000 || m_wdata[0] !== 32'h0000EE00 ||
        m_wmask[0] !== 32'h2 || m_ren[0] !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL sb_req got wen=%b waddr=%h wdata=%h wmask=%h ren=%b want 1/80000000/0000ee00/00000002/0",
               m_wen[0], m_waddr[0], m_wdata[0], m_wmask[0], m_ren[0]);
    end
    finish_op(0, 2, 0);
    vectors++;
    if (wen_cnt[0] - w0 != 1) begin
      miscompares++;
      $display("[TB] FAIL sb_wen_cycles got %0d want 1", wen_cnt[0] - w0);
    end
    start_op(0, 32'h80000000, 32'h0, 3'b010, 1'b1, 1'b0, 32'h8001EE34, 1'b0);
    finish_op(0, 2, 0);
    poke(0, 1, 32'h0);
    start_op(0, 32'h80000006, 32'h1234ABCD, 3'b001, 1'b0, 1'b1, 32'h0, 1'b0);
    vectors++;
    if (m_wdata[0] !== 32'hABCD0000 || m_wmask[0] !== 32'hC) begin
      miscompares++;
      $display("[TB] FAIL sh_req got wdata=%h wmask=%h want abcd0000/0000000c", m_wdata[0], m_wmask[0]);
    end
    finish_op(0, 2, 0);
    start_op(0, 32'h80000004, 32'h0, 3'b010, 1'b1, 1'b0, 32'hABCD0000, 1'b0);
    finish_op(0, 2, 0);
    start_op(0, 32'h80000008, 32'hCAFEF00D, 3'b010, 1'b0, 1'b1, 32'h0, 1'b0);
    finish_op(0, 2, 0);
    start_op(0, 32'h8000000A, 32'h0, 3'b001, 1'b1, 1'b0, 32'hFFFFCAFE, 1'b0);
    finish_op(0, 2, 0);
  endtask

  typedef struct packed {
    logic [31:0] a;
    logic [2:0]  f;
    logic        ld;
    logic        st;
  } err_vec_t;

  task automatic test_errors();
    err_vec_t tbl[8];
    int r0, w0;
    tbl[0] = '{a: 32'h80000002, f: 3'b010, ld: 1'b1, st: 1'b0};
    tbl[1] = '{a: 32'h80000001, f: 3'b001, ld: 1'b1, st: 1'b0};
    tbl[2] = '{a: 32'h80000003, f: 3'b010, ld: 1'b0, st: 1'b1};
    tbl[3] = '{a: 32'h80000005, f: 3'b001, ld: 1'b0, st: 1'b1};
    tbl[4] = '{a: 32'h80000000, f: 3'b011, ld: 1'b1, st: 1'b0};
    tbl[5] = '{a: 32'h80000000, f: 3'b100, ld: 1'b0, st: 1'b1};
    tbl[6] = '{a: 32'h80000000, f: 3'b000, ld: 1'b1, st: 1'b1};
    tbl[7] = '{a: 32'h80000000, f: 3'b010, ld: 1'b0, st: 1'b0};
    for (int i = 0; i < 8; i++) begin
      r0 = ren_cnt[0];
      w0 = wen_cnt[0];
      start_op(0, tbl[i].a, 32'hFFFFFFFF, tbl[i].f, tbl[i].ld, tbl[i].st, 32'h0, 1'b1);
      finish_op(0, 1, 0);
      vectors++;
      if (ren_cnt[0] != r0 || wen_cnt[0] != w0) begin
        miscompares++;
        $display("[TB] FAIL err_no_access case=%0d got ren=%0d wen=%0d want 0/0",
                 i, ren_cnt[0] - r0, wen_cnt[0] - w0);
      end
    end
    start_op(0, 32'h80000000, 32'h0, 3'b010, 1'b1, 1'b0, 32'h8001EE34, 1'b0);
    finish_op(0, 2, 0);
  endtask

  task automatic test_lat3();
    int r0, w0;
    poke(1, 2, 32'hDEADBEEF);
    r0 = ren_cnt[1];
    start_op(1, 32'h80000008, 32'h0, 3'b010, 1'b1, 1'b0, 32'hDEADBEEF, 1'b0);
    finish_op(1, 4, 4);
    vectors++;
    if (ren_cnt[1] - r0 != 3) begin
      miscompares++;
      $display("[TB] FAIL lat3_ren_cycles got %0d want 3", ren_cnt[1] - r0);
    end
    start_op(1, 32'h8000000A, 32'h0, 3'b100, 1'b1, 1'b0, 32'h000000AD, 1'b0);
    finish_op(1, 4, 0);
    w0 = wen_cnt[1];
    start_op(1, 32'h8000000B, 32'h00000055, 3'b000, 1'b0, 1'b1, 32'h0, 1'b0);
    finish_op(1, 4, 0);
    vectors++;
    if (wen_cnt[1] - w0 != 1) begin
      miscompares++;
      $display("[TB] FAIL lat3_wen_cycles got %0d want 1", wen_cnt[1] - w0);
    end
    start_op(1, 32'h80000008, 32'h0, 3'b010, 1'b1, 1'b0, 32'h55ADBEEF, 1'b0);
    finish_op(1, 4, 0);
    start_op(1, 32'h80000009, 32'h0, 3'b010, 1'b1, 1'b0, 32'h0, 1'b1);
    finish_op(1, 1, 2);
  endtask

  task automatic test_reset_mid_store();
    int w0;
    w0 = wen_cnt[1];
    start_op(1, 32'h8000000C, 32'h12345678, 3'b010, 1'b0, 1'b1, 32'h0, 1'b0);
    vectors++;
    if (m_wen[1] !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL sw_first_wen got %b want 1", m_wen[1]);
    end
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    void'(sb.pop_back());
    vectors++;
    if (in_ready[1] !== 1'b1 || out_valid[1] !== 1'b0 || m_wen[1] !== 1'b0 || m_ren[1] !== 1'b0 ||
        (m_waddr[1] | m_wdata[1] | m_wmask[1] | out_rdata[1]) !== 32'h0) begin
      miscompares++;
      $display("[TB] FAIL async_reset got ready=%b valid=%b wen=%b ren=%b wdata=%h want 1/0/0/0/0",
               in_ready[1], out_valid[1], m_wen[1], m_ren[1], m_wdata[1]);
    end
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    vectors++;
    if (wen_cnt[1] - w0 != 1 || in_ready[1] !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL no_second_write got wen=%0d ready=%b want 1/1", wen_cnt[1] - w0, in_ready[1]);
    end
    vectors++;
    if (mem[1][3] !== 32'h12345678) begin
      miscompares++;
      $display("[TB] FAIL sw_mem_word got %h want 12345678", mem[1][3]);
    end
    start_op(1, 32'h8000000C, 32'h0, 3'b010, 1'b1, 1'b0, 32'h12345678, 1'b0);
    finish_op(1, 4, 0);
  endtask

  initial begin
    test_reset();
    test_load_byte();
    test_load_half();
    test_store();
    test_errors();
    test_lat3();
    test_reset_mid_store();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog got timeout want completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
